// File: rtl/audio_adc_deserializer_if.sv
// Stereo sample stream from the I2S deserializer to its consumer.
// The head pair is presented with a valid/ready handshake.
`timescale 1ns/1ps
interface audio_adc_deserializer_if #(
    parameter int SAMPLE_WIDTH = 24
) ();
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_valid;
    logic                    sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// I2S ADC capture into a stereo-pair FIFO; a pair is pushed 1 clk after the right LSB is taken, head visible 1 clk later.
// Backpressure: sample_ready holds pairs in the FIFO; a pair arriving while full with no pop is dropped and flags overflow.
`timescale 1ns/1ps
module audio_adc_deserializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      aud_bclk,
    input  logic                      aud_adclrck,
    input  logic                      aud_adcdat,
    audio_adc_deserializer_if.master  smp,
    output logic                      overflow,
    output logic                      frame_err,
    input  logic                      clear_status
);
    localparam int CNT_W = $clog2(SAMPLE_WIDTH);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} state_t;

    state_t                  state;
    logic [2:0]              bclk_sync;
    logic [1:0]              lrck_sync;
    logic [1:0]              dat_sync;
    logic                    bclk_rise;
    logic                    lrck_last;
    logic                    lrck_seen;
    logic                    lrck_chg;
    logic                    dat_dly;
    logic                    chan;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] word;
    logic [SAMPLE_WIDTH-1:0] word_nxt;
    logic [SAMPLE_WIDTH-1:0] left_dat;
    logic [SAMPLE_WIDTH-1:0] right_dat;
    logic                    left_vld;
    logic                    pair_vld;

    // bclk_sync[2] is the previous value of the synchronized bit clock
    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lrck_chg  = lrck_seen && (lrck_sync[1] != lrck_last);
    assign word_nxt  = {word[SAMPLE_WIDTH-2:0], dat_dly};

    // Data is consumed one bit clock behind lrck so the DELAY state swallows the I2S delay slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            lrck_last <= 1'b0;
            lrck_seen <= 1'b0;
            dat_dly   <= 1'b0;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            word      <= '0;
            left_dat  <= '0;
            right_dat <= '0;
            left_vld  <= 1'b0;
            pair_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lrck_sync <= {lrck_sync[0], aud_adclrck};
            dat_sync  <= {dat_sync[0], aud_adcdat};
            pair_vld  <= 1'b0;
            if (bclk_rise) begin
                lrck_last <= lrck_sync[1];
                lrck_seen <= 1'b1;
                dat_dly   <= dat_sync[1];
                case (state)
                    IDLE: begin
                        if (lrck_chg) begin
                            state <= DELAY;
                            chan  <= lrck_sync[1];
                        end
                    end
                    DELAY, SHIFT: begin
                        if (lrck_chg) begin
                            state     <= DELAY;
                            chan      <= lrck_sync[1];
                            frame_err <= 1'b1;
                            left_vld  <= 1'b0;
                        end else if (state == DELAY) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            word    <= word_nxt;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                                if (!chan) begin
                                    left_dat <= word_nxt;
                                    left_vld <= 1'b1;
                                end else if (left_vld) begin
                                    right_dat <= word_nxt;
                                    pair_vld  <= 1'b1;
                                    left_vld  <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (lrck_chg) begin
                            state <= DELAY;
                            chan  <= lrck_sync[1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (clear_status) begin
                frame_err <= 1'b0;
            end
        end
    end

    logic [SAMPLE_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           rd_nxt;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;
    logic                    pop;
    logic                    push_ok;
    logic                    bypass;

    always_comb begin
        pop       = smp.sample_valid && smp.sample_ready;
        push_ok   = pair_vld && ((count != FULL_CNT) || pop);
        count_nxt = count + CW'(push_ok) - CW'(pop);
        rd_nxt    = rd_ptr + AW'(pop);
        // New pair becomes the head directly when nothing else remains queued
        bypass    = push_ok && (count == CW'(pop));
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_left[wr_ptr]  <= left_dat;
            mem_right[wr_ptr] <= right_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            smp.sample_valid <= 1'b0;
            smp.sample_left  <= '0;
            smp.sample_right <= '0;
            overflow         <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr           <= rd_nxt;
            count            <= count_nxt;
            smp.sample_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                if (bypass) begin
                    smp.sample_left  <= left_dat;
                    smp.sample_right <= right_dat;
                end else begin
                    smp.sample_left  <= mem_left[rd_nxt];
                    smp.sample_right <= mem_right[rd_nxt];
                end
            end
            if (pair_vld && !push_ok) begin
                overflow <= 1'b1;
            end
            if (clear_status) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Bench for the I2S deserializer: drives I2S frames on the codec pins and compares popped pairs with an expected queue.
`timescale 1ns/1ps
module tb_audio_adc_deserializer;
    localparam int SW    = 24;
    localparam int DEPTH = 4;
    localparam int SLOTS = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic aud_bclk = 1'b0;
    logic aud_adclrck = 1'b1;
    logic aud_adcdat = 1'b0;
    logic clear_status = 1'b0;
    logic overflow;
    logic frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_cycles = 0;
    logic [2*SW-1:0] recv_q[$];
    logic [2*SW-1:0] exp_q[$];

    audio_adc_deserializer_if #(.SAMPLE_WIDTH(SW)) smp_if ();

    audio_adc_deserializer #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .smp          (smp_if),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .clear_status (clear_status)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (smp_if.sample_valid) vld_cycles++;
        if (smp_if.sample_valid && smp_if.sample_ready && !reset)
            recv_q.push_back({smp_if.sample_left, smp_if.sample_right});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // One bit-clock slot: lrck/data change with the falling edge, rising edge mid-slot
    task automatic slot(input logic lr, input logic d, input bit pulse);
        aud_bclk = 1'b0;
        aud_adclrck = lr;
        aud_adcdat = d;
        repeat (8) @(posedge clk);
        #5 aud_bclk = 1'b1;
        if (pulse) begin
            fork
                begin
                    repeat (3) @(posedge clk);
                    #1 smp_if.sample_ready = 1'b1;
                    @(posedge clk);
                    #1 smp_if.sample_ready = 1'b0;
                end
            join_none
        end
        repeat (8) @(posedge clk);
        #5;
    endtask

    // I2S channel: slot 0 is the delay slot, then nbits MSB-first, then padding
    task automatic send_chan(input logic lr, input logic [SW-1:0] w, input int nbits,
                             input int slots, input int pulse_slot, input int rst_slot);
        for (int i = 0; i < slots; i++) begin
            logic d;
            if (i == 0 || i > nbits) d = 1'($urandom);
            else                     d = w[SW-i];
            if (i == rst_slot) reset = 1'b1;
            slot(lr, d, i == pulse_slot);
            if (i == rst_slot) reset = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int pulse_slot);
        send_chan(1'b0, l, SW, SLOTS, -1, -1);
        send_chan(1'b1, r, SW, SLOTS, pulse_slot, -1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 smp_if.sample_ready = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_status = 1'b1;
        @(posedge clk);
        #1 clear_status = 1'b0;
    endtask

    task automatic compare_queues(input string name);
        n_tests++;
        if (recv_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d pairs, want %0d", name, recv_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= recv_q.size() || recv_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_pair%0d: got %h, want %h", name, i,
                         (i < recv_q.size()) ? recv_q[i] : {2*SW{1'bx}}, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        smp_if.sample_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) slot(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (smp_if.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", smp_if.sample_valid); end
        n_tests++;
        if ({smp_if.sample_left, smp_if.sample_right} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h want 0", smp_if.sample_left, smp_if.sample_right);
        end
        n_tests++;
        if ({overflow, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {overflow, frame_err}); end
    endtask

    task automatic test_single_frame();
        recv_q.delete(); exp_q.delete();
        set_ready(1'b1);
        vld_cycles = 0;
        send_frame(24'hA5A5A5, 24'h123456, -1);
        exp_q.push_back({24'hA5A5A5, 24'h123456});
        repeat (20) @(posedge clk);
        compare_queues("single");
        n_tests++;
        if (vld_cycles != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d cycles want 1", vld_cycles); end
    endtask

    task automatic test_overflow();
        recv_q.delete(); exp_q.delete();
        set_ready(1'b0);
        for (int n = 1; n <= 5; n++) begin
            logic [SW-1:0] l, r;
            l = SW'(n);
            r = ~l;
            send_frame(l, r, -1);
            if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_tests++;
        if (recv_q.size() != 0) begin n_fail++; $display("FAIL ovf_held: got %0d pops want 0", recv_q.size()); end
        n_tests++;
        if (smp_if.sample_valid !== 1'b1 || {smp_if.sample_left, smp_if.sample_right} !== exp_q[0]) begin
            n_fail++; $display("FAIL ovf_head: got %b %h want 1 %h", smp_if.sample_valid,
                               {smp_if.sample_left, smp_if.sample_right}, exp_q[0]);
        end
        set_ready(1'b1);
        repeat (10) @(posedge clk);
        compare_queues("ovf_drain");
        n_tests++;
        if (smp_if.sample_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", smp_if.sample_valid); end
        n_tests++;
        if (smp_if.sample_left !== 24'd4) begin n_fail++; $display("FAIL ovf_hold_last: got %h want 000004", smp_if.sample_left); end
        pulse_clear();
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        recv_q.delete(); exp_q.delete();
        set_ready(1'b0);
        for (int n = 0; n < DEPTH + 1; n++) begin
            logic [SW-1:0] l, r;
            l = SW'($urandom);
            r = SW'($urandom);
            exp_q.push_back({l, r});
            send_frame(l, r, (n == DEPTH) ? 25 : -1);
        end
        repeat (4) @(posedge clk);
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf: got %b want 0", overflow); end
        n_tests++;
        if ({smp_if.sample_left, smp_if.sample_right} !== exp_q[1]) begin
            n_fail++; $display("FAIL fullpp_head: got %h want %h", {smp_if.sample_left, smp_if.sample_right}, exp_q[1]);
        end
        set_ready(1'b1);
        repeat (10) @(posedge clk);
        compare_queues("fullpp");
    endtask

    task automatic test_frame_err();
        logic [SW-1:0] l, r;
        recv_q.delete(); exp_q.delete();
        set_ready(1'b1);
        send_chan(1'b0, SW'($urandom), 10, 11, -1, -1);
        send_chan(1'b1, SW'($urandom), SW, SLOTS, -1, -1);
        n_tests++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
        n_tests++;
        if (recv_q.size() != 0) begin n_fail++; $display("FAIL ferr_no_pair: got %0d pairs want 0", recv_q.size()); end
        l = SW'($urandom);
        r = SW'($urandom);
        send_frame(l, r, -1);
        exp_q.push_back({l, r});
        repeat (10) @(posedge clk);
        compare_queues("ferr_next");
        n_tests++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
        pulse_clear();
        n_tests++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
    endtask

    task automatic test_reset_mid_word();
        logic [SW-1:0] l, r;
        recv_q.delete(); exp_q.delete();
        set_ready(1'b0);
        send_frame(SW'($urandom) | 24'h1, SW'($urandom), -1);
        n_tests++;
        if (smp_if.sample_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", smp_if.sample_valid); end
        send_chan(1'b0, SW'($urandom), SW, SLOTS, -1, -1);
        send_chan(1'b1, SW'($urandom), SW, SLOTS, -1, 12);
        n_tests++;
        if ({smp_if.sample_valid, smp_if.sample_left, smp_if.sample_right, overflow, frame_err} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b %h %h %b %b want all 0", smp_if.sample_valid,
                               smp_if.sample_left, smp_if.sample_right, overflow, frame_err);
        end
        set_ready(1'b1);
        l = SW'($urandom);
        r = SW'($urandom);
        send_frame(l, r, -1);
        exp_q.push_back({l, r});
        repeat (10) @(posedge clk);
        compare_queues("rst_first");
    endtask

    task automatic test_back_to_back();
        bit done;
        recv_q.delete(); exp_q.delete();
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    logic [SW-1:0] l, r;
                    l = SW'($urandom);
                    r = SW'($urandom);
                    exp_q.push_back({l, r});
                    send_frame(l, r, -1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 smp_if.sample_ready = 1'($urandom);
                end
            end
        join
        set_ready(1'b1);
        repeat (20) @(posedge clk);
        compare_queues("b2b");
        n_tests++;
        if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_status: got %b%b want 00", overflow, frame_err);
        end
    endtask

    initial begin
        smp_if.sample_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_full_push_pop();
        test_frame_err();
        test_reset_mid_word();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
